// File: rtl/fb_pkg.sv
// Shared constants and state encoding for the double-buffered framebuffer sequencer.
package fb_pkg;

  localparam int FB_PIXELS     = 4096;
  localparam int FB_BANK_WORDS = 2048;
  localparam int FB_ADDR_W     = 12;
  // Pixel-index bit that selects between the upper and lower panel banks.
  localparam int FB_BANK_BIT   = $clog2(FB_BANK_WORDS);

  typedef enum logic {
    S_FILL      = 1'b0,
    S_WAIT_SWAP = 1'b1
  } fb_state_e;

endpackage

// File: rtl/ms_tick_divider.sv
// Free-running prescaler emitting a one-cycle tick every TICK_DIV cycles.
// Restart reloads the count so the first tick lands exactly TICK_DIV cycles later.
module ms_tick_divider #(
  parameter int TICK_DIV = 12000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    if (i_restart || count_q == '0) count_d = RELOAD;
    else                            count_d = count_q - 1'b1;
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge i_clk) begin
    if (i_reset) count_q <= RELOAD;
    else         count_q <= count_d;
  end

  assign o_tick = (count_q == '0);

endmodule

// File: rtl/framebuffer_page_controller.sv
// Loads frames into the back page and swaps pages at a panel scan boundary once
// the displayed frame's hold time has elapsed.
module framebuffer_page_controller
  import fb_pkg::*;
#(
  parameter int TICK_DIV    = 12000,
  parameter int DELAY_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_wr_valid,
  output logic                   o_wr_ready,
  input  logic [15:0]            i_wr_data,
  input  logic [DELAY_WIDTH-1:0] i_frame_delay,
  output logic [FB_ADDR_W-1:0]   o_ram_wr_addr,
  output logic [15:0]            o_ram_wr_data,
  output logic                   o_ram_b1_wr_en,
  output logic                   o_ram_b2_wr_en,
  input  logic [10:0]            i_panel_addr,
  output logic [FB_ADDR_W-1:0]   o_ram_rd_addr,
  input  logic                   i_panel_frame_done,
  output logic                   o_display_page,
  output logic                   o_swap_stb
);

  fb_state_e                state_q, state_d;
  logic [FB_ADDR_W-1:0]     pixel_index_q;
  logic                     display_page_q;
  logic [DELAY_WIDTH-1:0]   hold_q, pending_q;
  logic [FB_ADDR_W-1:0]     wr_addr_q;
  logic [15:0]              wr_data_q;
  logic                     wr_b1_q, wr_b2_q, swap_stb_q;
  logic                     accept, last_accept, swap, tick;

  assign accept      = i_wr_valid && o_wr_ready;
  assign last_accept = accept && (pixel_index_q == FB_ADDR_W'(FB_PIXELS - 1));
  // Registered hold value: a tick reaching zero this cycle cannot qualify a swap yet.
  assign swap        = (state_q == S_WAIT_SWAP) && (hold_q == '0) && i_panel_frame_done;

  ms_tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_restart (swap),
    .o_tick    (tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_FILL;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:      if (last_accept) state_d = S_WAIT_SWAP;
      S_WAIT_SWAP: if (swap)        state_d = S_FILL;
      default:                      state_d = S_FILL;
    endcase
  end

  always_comb begin
    o_wr_ready = (state_q == S_FILL) && !i_reset;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pixel_index_q  <= '0;
      display_page_q <= 1'b0;
      hold_q         <= '0;
      pending_q      <= '0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      wr_b1_q        <= 1'b0;
      wr_b2_q        <= 1'b0;
      swap_stb_q     <= 1'b0;
    end else begin
      wr_b1_q    <= accept && !pixel_index_q[FB_BANK_BIT];
      wr_b2_q    <= accept &&  pixel_index_q[FB_BANK_BIT];
      swap_stb_q <= swap;
      if (accept) begin
        wr_addr_q     <= {~display_page_q, pixel_index_q[FB_BANK_BIT-1:0]};
        wr_data_q     <= i_wr_data;
        pixel_index_q <= pixel_index_q + 1'b1;
        if (pixel_index_q == '0) pending_q <= i_frame_delay;
      end
      if (swap) begin
        display_page_q <= ~display_page_q;
        hold_q         <= pending_q;
      end else if (tick && hold_q != '0) begin
        hold_q <= hold_q - 1'b1;
      end
    end
  end

  assign o_ram_wr_addr  = wr_addr_q;
  assign o_ram_wr_data  = wr_data_q;
  assign o_ram_b1_wr_en = wr_b1_q;
  assign o_ram_b2_wr_en = wr_b2_q;
  assign o_ram_rd_addr  = {display_page_q, i_panel_addr};
  assign o_display_page = display_page_q;
  assign o_swap_stb     = swap_stb_q;

endmodule

// File: tb/tb_framebuffer_page_controller.sv
// Randomized bench for framebuffer_page_controller against a frame/time-level model.
module tb_framebuffer_page_controller;

  localparam int TD     = 4;
  localparam int DW     = 16;
  localparam int PIXELS = 4096;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_wr_valid = 1'b0;
  logic          o_wr_ready;
  logic [15:0]   i_wr_data = '0;
  logic [DW-1:0] i_frame_delay = '0;
  logic [11:0]   o_ram_wr_addr;
  logic [15:0]   o_ram_wr_data;
  logic          o_ram_b1_wr_en, o_ram_b2_wr_en;
  logic [10:0]   i_panel_addr = '0;
  logic [11:0]   o_ram_rd_addr;
  logic          i_panel_frame_done = 1'b0;
  logic          o_display_page, o_swap_stb;

  always #5 clk = ~clk;

  framebuffer_page_controller #(.TICK_DIV(TD), .DELAY_WIDTH(DW)) dut (
    .i_clk              (clk),
    .i_reset            (i_reset),
    .i_wr_valid         (i_wr_valid),
    .o_wr_ready         (o_wr_ready),
    .i_wr_data          (i_wr_data),
    .i_frame_delay      (i_frame_delay),
    .o_ram_wr_addr      (o_ram_wr_addr),
    .o_ram_wr_data      (o_ram_wr_data),
    .o_ram_b1_wr_en     (o_ram_b1_wr_en),
    .o_ram_b2_wr_en     (o_ram_b2_wr_en),
    .i_panel_addr       (i_panel_addr),
    .o_ram_rd_addr      (o_ram_rd_addr),
    .i_panel_frame_done (i_panel_frame_done),
    .o_display_page     (o_display_page),
    .o_swap_stb         (o_swap_stb)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: page shown, pixels taken this frame, and the earliest cycle
  // at which a frame_done pulse may swap (swap output cycle + delay * TD).
  bit m_page, m_wait;
  int m_count, m_expire, m_pending;
  int last_swap = 0, prev_swap = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_page = 0; m_wait = 0; m_count = 0; m_expire = 0; m_pending = 0;
  endtask

  task automatic step(input bit valid, input logic [15:0] data, input logic [DW-1:0] delay,
                      input bit fd, input logic [10:0] paddr, output bit acc);
    bit swp, e_b1, e_b2;
    logic [11:0] e_addr;
    @(negedge clk);
    i_wr_valid = valid; i_wr_data = data; i_frame_delay = delay;
    i_panel_frame_done = fd; i_panel_addr = paddr;
    #1;
    check("wr_ready", 32'(o_wr_ready), 32'(!m_wait));
    check("rd_addr", 32'(o_ram_rd_addr), 32'({m_page, paddr}));
    acc    = valid && !m_wait;
    swp    = m_wait && fd && (cyc >= m_expire);
    e_addr = {~m_page, 11'(m_count)};
    e_b1   = acc && (m_count <  PIXELS / 2);
    e_b2   = acc && (m_count >= PIXELS / 2);
    if (acc) begin
      if (m_count == 0) m_pending = int'(delay);
      m_count++;
      if (m_count == PIXELS) begin m_count = 0; m_wait = 1; end
    end
    if (swp) begin
      m_page   = ~m_page;
      m_wait   = 0;
      m_expire = cyc + 1 + m_pending * TD;
    end
    @(posedge clk);
    #1;
    check("b1_en", 32'(o_ram_b1_wr_en), 32'(e_b1));
    check("b2_en", 32'(o_ram_b2_wr_en), 32'(e_b2));
    check("swap_stb", 32'(o_swap_stb), 32'(swp));
    check("display_page", 32'(o_display_page), 32'(m_page));
    if (acc) begin
      check("wr_addr", 32'(o_ram_wr_addr), 32'(e_addr));
      check("wr_data", 32'(o_ram_wr_data), 32'(data));
    end
    if (o_swap_stb) begin prev_swap = last_swap; last_swap = cyc; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset = 1; i_wr_valid = 0; i_panel_frame_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_ready", 32'(o_wr_ready), 32'd0);
      check("rst_b1", 32'(o_ram_b1_wr_en), 32'd0);
      check("rst_b2", 32'(o_ram_b2_wr_en), 32'd0);
      check("rst_stb", 32'(o_swap_stb), 32'd0);
      check("rst_page", 32'(o_display_page), 32'd0);
    end
    @(negedge clk);
    i_reset = 0;
    model_reset();
  endtask

  task automatic feed(input int n, input logic [DW-1:0] delay, input int idle_pct,
                      input bit idx_data, input bit fd_last);
    int  got = 0;
    bit  acc, v, fd;
    for (int c = 0; c < 4 * n + 100 && got < n; c++) begin
      v  = ($urandom_range(99) >= idle_pct);
      fd = fd_last ? (v && got == n - 1) : ($urandom_range(63) == 0);
      step(v, idx_data ? 16'(got) : 16'($urandom), delay, fd, 11'($urandom), acc);
      if (acc) got++;
    end
    if (got < n) check("feed_timeout", 32'(got), 32'(n));
  endtask

  task automatic wait_swap(input int bound);
    bit acc;
    for (int c = 0; c < bound && m_wait; c++)
      step(1'($urandom), 16'($urandom), DW'($urandom), 1'b1, 11'($urandom), acc);
    if (m_wait) check("swap_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int c = 0; c < n; c++)
      step(1'($urandom), 16'($urandom), DW'($urandom), 1'b0, 11'($urandom), acc);
  endtask

  initial begin
    bit acc;
    model_reset();
    do_reset();

    // Frame 1: data = index, no gaps, then no swap without frame_done.
    feed(PIXELS, 16'd2, 0, 1'b1, 1'b0);
    idle(6);
    check("no_early_swap", 32'(o_display_page), 32'd0);
    wait_swap(10);
    step(1'b0, 16'h0, 16'd0, 1'b0, 11'h123, acc);
    check("rd_addr_0x123", 32'(o_ram_rd_addr), 32'h923);

    // Frame 2: long hold, random gaps; frame 3 then waits out the exact hold.
    feed(PIXELS, 16'd1030, 25, 1'b0, 1'b0);
    wait_swap(20);
    feed(PIXELS, 16'd3, 0, 1'b0, 1'b0);
    wait_swap(200);
    check("hold_1030ms", 32'(last_swap - prev_swap), 32'(1030 * TD + 1));

    // Frame 4: frame_done on the last-pixel accept must not swap.
    feed(PIXELS, 16'd0, 10, 1'b0, 1'b1);
    check("same_cycle_no_swap", 32'(o_swap_stb), 32'd0);
    idle(4);
    wait_swap(10);

    // Partial frame aborted by reset, then a complete frame from pixel 0.
    feed(1000, 16'd1, 30, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 16'hBEEF, 16'd1, 1'b0, 11'h0, acc);
    check("post_rst_addr", 32'(o_ram_wr_addr), 32'h800);
    check("post_rst_b1", 32'(o_ram_b1_wr_en), 32'd1);
    check("post_rst_page", 32'(o_display_page), 32'd0);
    feed(PIXELS - 1, 16'd1, 20, 1'b0, 1'b0);
    wait_swap(20);
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
